// File: rtl/dmem_responder.sv
// dmem_responder
//   Handshaked data-memory slave for the processor load/store port. One
//   word-wide, byte-maskable read or write is accepted per Req/Ack
//   transaction. After a programmable number of wait cycles, Ack pulses
//   for exactly one cycle.
//
// Parameters
//   ADDR_WIDTH   word-index bits; the array holds 2**ADDR_WIDTH 32-bit words
//   WAIT_STATES  extra cycles between request capture and Ack (0..15)
//   BASE_ADDR    byte address of word 0 (4-byte aligned)
//
// Ports
//   CLK      in   clock, rising edge
//   Reset_L  in   asynchronous active-low reset
//   Req      in   request, held high by the initiator until Ack is seen
//   Wr       in   1 = write, 0 = read (sampled with Req)
//   Addr     in   byte address (sampled with Req)
//   WData    in   write data (sampled with Req)
//   ByteEn   in   write lane mask, bit i -> WData[8i+7:8i]
//   Ack      out  one-cycle completion pulse
//   RData    out  read data while Ack on an error-free read, else 0
//   Err      out  with Ack: misaligned or out-of-range access
//   Busy     out  high whenever a transaction is in flight
module dmem_responder #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic        Req,
    input  logic        Wr,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic [3:0]  ByteEn,
    output logic        Ack,
    output logic [31:0] RData,
    output logic        Err,
    output logic        Busy
);

    localparam int         DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Misaligned, below the base, or past the end of the array. The offset
    // is a wrapping 32-bit subtract, so the below-base case is caught
    // explicitly rather than through the range test.
    function automatic logic addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) ||
               (((a - BASE_ADDR) >> (ADDR_WIDTH + 2)) != 32'd0);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr_idx(input logic [31:0] a);
        return ADDR_WIDTH'((a - BASE_ADDR) >> 2);
    endfunction

    logic [31:0] mem [0:DEPTH-1];

    logic [1:0]  state;
    logic [3:0]  cnt;

    logic                  wr_p0;
    logic [ADDR_WIDTH-1:0] idx_p0;
    logic [31:0]           wdata_p0;
    logic [3:0]            be_p0;
    logic                  err_p0;

    logic                  take_req;
    logic                  go_resp;
    logic                  commit_en;
    logic                  commit_wr;
    logic                  commit_err;
    logic [ADDR_WIDTH-1:0] commit_idx;
    logic [31:0]           commit_data;
    logic [3:0]            commit_be;

    assign take_req = (state == S_IDLE) && Req;
    assign go_resp  = (take_req && (WAIT_STATES == 0)) ||
                      ((state == S_WAIT) && (cnt == 4'd0));

    // Control: only the FSM and wait counter are reset.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Req) begin
                        cnt   <= CNT_INIT;
                        state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // Req seen on this edge is deliberately ignored.
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- stage p0: request capture (data only, no reset) ----
    always_ff @(posedge CLK) begin
        if (take_req) begin
            wr_p0    <= Wr;
            idx_p0   <= addr_idx(Addr);
            wdata_p0 <= WData;
            be_p0    <= ByteEn;
            err_p0   <= addr_err(Addr);
        end
    end

    // With zero wait states the commit happens on the capture edge itself,
    // so the live inputs must be used instead of the not-yet-loaded copies.
    always_comb begin
        commit_wr   = wr_p0;
        commit_err  = err_p0;
        commit_idx  = idx_p0;
        commit_data = wdata_p0;
        commit_be   = be_p0;
        if (take_req && (WAIT_STATES == 0)) begin
            commit_wr   = Wr;
            commit_err  = addr_err(Addr);
            commit_idx  = addr_idx(Addr);
            commit_data = WData;
            commit_be   = ByteEn;
        end
        // Gate with Reset_L so an edge that arrives during reset cannot write.
        commit_en = Reset_L && go_resp && commit_wr && !commit_err;
    end

    // ---- stage p1: array write on the edge entering RESP ----
    always_ff @(posedge CLK) begin
        if (commit_en) begin
            for (int i = 0; i < 4; i++) begin
                if (commit_be[i]) begin
                    mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
                end
            end
        end
    end

    // Outputs are derived from registered state only; Req never reaches Ack.
    assign Ack   = (state == S_RESP);
    assign Busy  = (state != S_IDLE);
    assign Err   = Ack && err_p0;
    assign RData = (Ack && !wr_p0 && !err_p0) ? mem[idx_p0] : 32'd0;

endmodule
